// File: rtl/tree_light_sequencer.sv
// tree_light_sequencer: step-rate prescaler driving four 8-bit light patterns
// (chase, fill, twinkle, blink) plus a star light that toggles every 4th step.
module tree_light_sequencer #(
   parameter int BASE_DIV = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [1:0] mode,
   input  logic [2:0] speed,
   input  logic       pause,
   output logic [7:0] leds,
   output logic       star,
   output logic       frame_tick
);

   localparam int PW = $clog2(8 * BASE_DIV);

   typedef enum logic [1:0] {
      MODE_CHASE   = 2'd0,
      MODE_FILL    = 2'd1,
      MODE_TWINKLE = 2'd2,
      MODE_BLINK   = 2'd3
   } mode_e;

   localparam logic [7:0] CHASE_INIT = 8'h01;
   localparam logic [7:0] LFSR_INIT  = 8'hA5;
   localparam logic [7:0] BLINK_A    = 8'h55;
   localparam logic [7:0] BLINK_B    = 8'hAA;

   // Current state
   logic [PW-1:0] presc;
   mode_e         mode_q;
   logic          loaded;
   logic [1:0]    star_cnt;
   logic [7:0]    chase;
   logic [3:0]    fill_cnt;
   logic [7:0]    lfsr;
   logic          blink_ph;

   // Next state
   logic [PW-1:0] presc_d;
   mode_e         mode_d;
   logic          loaded_d;
   logic [1:0]    star_cnt_d;
   logic          star_d;
   logic [7:0]    chase_d;
   logic [3:0]    fill_cnt_d;
   logic [7:0]    lfsr_d;
   logic          blink_ph_d;
   logic [7:0]    leds_d;

   logic [PW-1:0] period_m1;
   logic          step;
   mode_e         mode_in;
   logic          lfsr_fb;

   // Terminal count for the selected speed; the >= compare lets a lowered
   // speed fire a step on the very next edge instead of waiting for a wrap.
   assign period_m1 = PW'((32'(speed) + 32'd1) * 32'(BASE_DIV) - 32'd1);
   assign step      = ena && !pause && (presc >= period_m1);
   assign mode_in   = mode_e'(mode);
   assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   // Thermometer pattern with cnt lit LEDs (cnt = 0..8).
   function automatic logic [7:0] fill_pattern(input logic [3:0] cnt);
      return 8'((9'd1 << cnt) - 9'd1);
   endfunction

   // Next-state logic: prescaler, mode load/advance, star counter.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned; a missing default here would infer a latch.
      presc_d    = presc;
      mode_d     = mode_q;
      loaded_d   = loaded;
      star_cnt_d = star_cnt;
      star_d     = star;
      chase_d    = chase;
      fill_cnt_d = fill_cnt;
      lfsr_d     = lfsr;
      blink_ph_d = blink_ph;
      leds_d     = leds;

      if (!ena)
         presc_d = '0;
      else if (!pause)
         presc_d = step ? '0 : presc + 1'b1;

      if (step) begin
         star_cnt_d = star_cnt + 2'd1;
         if (star_cnt == 2'd3)
            star_d = ~star;

         if (!loaded || (mode_in != mode_q)) begin
            // New (or first) mode: restart every pattern from its seed.
            mode_d     = mode_in;
            loaded_d   = 1'b1;
            chase_d    = CHASE_INIT;
            fill_cnt_d = 4'd0;
            lfsr_d     = LFSR_INIT;
            blink_ph_d = 1'b0;
            case (mode_in)
               MODE_CHASE:   leds_d = CHASE_INIT;
               MODE_FILL:    leds_d = 8'h00;
               MODE_TWINKLE: leds_d = LFSR_INIT;
               MODE_BLINK:   leds_d = BLINK_A;
               default:      leds_d = 8'h00;
            endcase
         end else begin
            case (mode_q)
               MODE_CHASE: begin
                  chase_d = {chase[6:0], chase[7]};
                  leds_d  = chase_d;
               end
               MODE_FILL: begin
                  fill_cnt_d = (fill_cnt == 4'd8) ? 4'd0 : fill_cnt + 4'd1;
                  leds_d     = fill_pattern(fill_cnt_d);
               end
               MODE_TWINKLE: begin
                  lfsr_d = {lfsr[6:0], lfsr_fb};
                  leds_d = lfsr_d;
               end
               MODE_BLINK: begin
                  blink_ph_d = ~blink_ph;
                  leds_d     = blink_ph_d ? BLINK_B : BLINK_A;
               end
               default: leds_d = leds;
            endcase
         end
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its peers.
      if (!rst_n) begin
         presc      <= '0;
         mode_q     <= MODE_CHASE;
         loaded     <= 1'b0;
         star_cnt   <= 2'd0;
         star       <= 1'b0;
         chase      <= CHASE_INIT;
         fill_cnt   <= 4'd0;
         lfsr       <= LFSR_INIT;
         blink_ph   <= 1'b0;
         leds       <= 8'h00;
         frame_tick <= 1'b0;
      end else begin
         presc      <= presc_d;
         mode_q     <= mode_d;
         loaded     <= loaded_d;
         star_cnt   <= star_cnt_d;
         star       <= star_d;
         chase      <= chase_d;
         fill_cnt   <= fill_cnt_d;
         lfsr       <= lfsr_d;
         blink_ph   <= blink_ph_d;
         leds       <= leds_d;
         frame_tick <= step;
      end
   end

endmodule
